// File: rtl/burst_sum_accumulator.sv
// burst_sum_accumulator
// Sums a burst of unsigned adder results into a wide accumulator and presents
// one registered total per burst. A burst closes on din_last or when it reaches
// MAX_BEATS beats. The result is held until the sink takes it. Input is not
// accepted while a result is pending, which costs one bubble per burst.
module burst_sum_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int MAX_BEATS  = 16,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH:0]   din,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic                  din_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic [CW-1:0]         dout_count,
    output logic                  dout_overflow,
    output logic                  dout_last_seen,
    output logic                  dout_valid,
    input  logic                  dout_ready
);

    // Number of zero bits that widen din to the ACC_WIDTH+1 sum width.
    localparam int PAD_W = ACC_WIDTH - DATA_WIDTH;
    // Beat count at which a burst is force-closed.
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_out_q, ovf_out_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;

    logic                 accept;
    logic                 close_burst;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [CW-1:0]        cnt_inc;
    logic                 ovf_new;

    // Ready is a pure decode of the state register so it never depends
    // combinationally on either handshake partner.
    assign din_ready = (state_q == ST_ACC);
    assign accept    = din_valid && din_ready;

    // One bit wider than the accumulator so the carry out is visible.
    assign sum_ext     = {1'b0, acc_q} + {{PAD_W{1'b0}}, din};
    assign cnt_inc     = cnt_q + 1'b1;
    assign ovf_new     = ovf_q | sum_ext[ACC_WIDTH];
    assign close_burst = accept && (din_last || (cnt_inc == MAX_CNT));

    assign dout           = dout_q;
    assign dout_count     = count_q;
    assign dout_overflow  = ovf_out_q;
    assign dout_last_seen = last_q;
    assign dout_valid     = valid_q;

    // Next-state and datapath decisions; every target holds by default.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        dout_d    = dout_q;
        count_d   = count_q;
        ovf_out_d = ovf_out_q;
        last_d    = last_q;
        valid_d   = valid_q;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    acc_d = sum_ext[ACC_WIDTH-1:0];
                    ovf_d = ovf_new;
                    cnt_d = cnt_inc;
                end
                if (close_burst) begin
                    // Publish the total including this beat, then start the
                    // next burst from a clean accumulator.
                    dout_d    = sum_ext[ACC_WIDTH-1:0];
                    count_d   = cnt_inc;
                    ovf_out_d = ovf_new;
                    last_d    = din_last;
                    valid_d   = 1'b1;
                    state_d   = ST_DONE;
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                end
            end
            ST_DONE: begin
                // Result data is left in place after the handshake; only
                // valid drops.
                if (valid_q && dout_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State, accumulator and result registers; reset discards any partial
    // or pending burst.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            dout_q    <= '0;
            count_q   <= '0;
            ovf_out_q <= 1'b0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            count_q   <= count_d;
            ovf_out_q <= ovf_out_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_burst_sum_accumulator.sv
// Directed bench for burst_sum_accumulator. Four instances share the input
// side: default sizing, a 10-bit accumulator, MAX_BEATS=4 and MAX_BEATS=1.
// Each phase resets all of them and checks the instance selected by sel.
module tb_burst_sum_accumulator;

    logic        clk;
    logic        resetn;
    logic [8:0]  din;
    logic        din_valid;
    logic        din_last;
    logic        dout_ready;

    // Default instance (8/16/16)
    logic        m_ready, m_ovf, m_last, m_valid;
    logic [15:0] m_dout;
    logic [4:0]  m_count;
    // ACC_WIDTH=10
    logic        o_ready, o_ovf, o_last, o_valid;
    logic [9:0]  o_dout;
    logic [4:0]  o_count;
    // MAX_BEATS=4
    logic        f_ready, f_ovf, f_last, f_valid;
    logic [15:0] f_dout;
    logic [2:0]  f_count;
    // MAX_BEATS=1
    logic        s_ready, s_ovf, s_last, s_valid;
    logic [15:0] s_dout;
    logic [0:0]  s_count;

    int n_assert = 0;
    int n_fail   = 0;
    int sel      = 0;

    logic        sel_ready, sel_ovf, sel_last, sel_valid;
    logic [15:0] sel_dout;
    logic [4:0]  sel_count;

    burst_sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_BEATS(16)) u_main (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(m_ready), .dout(m_dout), .dout_count(m_count), .dout_overflow(m_ovf),
        .dout_last_seen(m_last), .dout_valid(m_valid), .dout_ready(dout_ready));

    burst_sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .MAX_BEATS(16)) u_ovf (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(o_ready), .dout(o_dout), .dout_count(o_count), .dout_overflow(o_ovf),
        .dout_last_seen(o_last), .dout_valid(o_valid), .dout_ready(dout_ready));

    burst_sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_BEATS(4)) u_max4 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(f_ready), .dout(f_dout), .dout_count(f_count), .dout_overflow(f_ovf),
        .dout_last_seen(f_last), .dout_valid(f_valid), .dout_ready(dout_ready));

    burst_sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_BEATS(1)) u_max1 (
        .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_last(din_last),
        .din_ready(s_ready), .dout(s_dout), .dout_count(s_count), .dout_overflow(s_ovf),
        .dout_last_seen(s_last), .dout_valid(s_valid), .dout_ready(dout_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the instance under test onto common observation signals.
    always_comb begin
        sel_ready = m_ready; sel_ovf = m_ovf; sel_last = m_last; sel_valid = m_valid;
        sel_dout  = m_dout;  sel_count = m_count;
        case (sel)
            1: begin
                sel_ready = o_ready; sel_ovf = o_ovf; sel_last = o_last; sel_valid = o_valid;
                sel_dout  = {6'd0, o_dout}; sel_count = o_count;
            end
            2: begin
                sel_ready = f_ready; sel_ovf = f_ovf; sel_last = f_last; sel_valid = f_valid;
                sel_dout  = f_dout; sel_count = {2'd0, f_count};
            end
            3: begin
                sel_ready = s_ready; sel_ovf = s_ovf; sel_last = s_last; sel_valid = s_valid;
                sel_dout  = s_dout; sel_count = {4'd0, s_count};
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic do_reset();
        din_valid  = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        resetn     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn     = 1'b1;
    endtask

    // Present one beat and hold it until the selected instance takes it.
    task automatic send(input string tag, input logic [8:0] d, input logic last);
        bit taken = 1'b0;
        din       = d;
        din_last  = last;
        din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (sel_ready) begin
                @(posedge clk);
                taken = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        din_valid = 1'b0;
        din_last  = 1'b0;
        if (!taken) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_res(input string tag, input int d, input int c, input logic o, input logic l);
        chk({tag, "_valid"}, {31'd0, sel_valid}, 32'd1);
        chk({tag, "_dout"},  {16'd0, sel_dout}, d);
        chk({tag, "_count"}, {27'd0, sel_count}, c);
        chk({tag, "_ovf"},   {31'd0, sel_ovf}, {31'd0, o});
        chk({tag, "_last"},  {31'd0, sel_last}, {31'd0, l});
        chk({tag, "_ready"}, {31'd0, sel_ready}, 32'd0);
    endtask

    task automatic handshake(input string tag);
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        chk({tag, "_hs_valid"}, {31'd0, sel_valid}, 32'd0);
        chk({tag, "_hs_ready"}, {31'd0, sel_ready}, 32'd1);
    endtask

    initial begin
        din = '0; din_valid = 1'b0; din_last = 1'b0; dout_ready = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        sel = 0;
        chk("rst_dout",  {16'd0, m_dout}, 32'd0);
        chk("rst_count", {27'd0, m_count}, 32'd0);
        chk("rst_ovf",   {31'd0, m_ovf}, 32'd0);
        chk("rst_last",  {31'd0, m_last}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, m_ready}, 32'd1);

        // Basic burst: 100 + 200 + 300 = 600
        sel = 0;
        do_reset();
        send("basic_b0", 9'd100, 1'b0);
        chk("basic_mid_valid", {31'd0, sel_valid}, 32'd0);
        send("basic_b1", 9'd200, 1'b0);
        send("basic_b2", 9'd300, 1'b1);
        check_res("basic", 600, 3, 1'b0, 1'b1);
        @(negedge clk);
        chk("basic_hold_ready", {31'd0, sel_ready}, 32'd0);
        handshake("basic");

        // Overflow with a 10-bit accumulator: 1533 mod 1024 = 509
        sel = 1;
        do_reset();
        send("ovf_b0", 9'd511, 1'b0);
        send("ovf_b1", 9'd511, 1'b0);
        send("ovf_b2", 9'd511, 1'b1);
        check_res("ovf", 509, 3, 1'b1, 1'b1);
        handshake("ovf");
        // Sticky flag must not leak into the next burst
        send("ovf_next", 9'd3, 1'b1);
        check_res("ovf_next", 3, 1, 1'b0, 1'b1);
        handshake("ovf_next");

        // Forced close at MAX_BEATS=4, then a one-beat burst
        sel = 2;
        do_reset();
        for (int i = 0; i < 4; i++) send("max_b", 9'd1, 1'b0);
        check_res("max_forced", 4, 4, 1'b0, 1'b0);
        handshake("max_forced");
        send("max_b4", 9'd1, 1'b1);
        check_res("max_tail", 1, 1, 1'b0, 1'b1);
        handshake("max_tail");
        // din_last on exactly the MAX_BEATS-th beat
        send("maxl_b0", 9'd10, 1'b0);
        send("maxl_b1", 9'd20, 1'b0);
        send("maxl_b2", 9'd30, 1'b0);
        send("maxl_b3", 9'd40, 1'b1);
        check_res("max_lastbeat", 100, 4, 1'b0, 1'b1);
        handshake("max_lastbeat");

        // Back-pressure: result held, pending beat 9 not absorbed
        sel = 0;
        do_reset();
        send("bp_b0", 9'd5, 1'b1);
        din = 9'd9; din_last = 1'b1; din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, sel_valid}, 32'd1);
            chk("bp_hold_dout",  {16'd0, sel_dout}, 32'd5);
            chk("bp_hold_count", {27'd0, sel_count}, 32'd1);
            chk("bp_hold_ready", {31'd0, sel_ready}, 32'd0);
        end
        dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        chk("bp_release_valid", {31'd0, sel_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, sel_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        din_valid = 1'b0; din_last = 1'b0;
        check_res("bp_nine", 9, 1, 1'b0, 1'b1);
        handshake("bp_nine");

        // Gapped input; din_last without din_valid must be ignored
        sel = 0;
        do_reset();
        din = 9'd5; din_last = 1'b0; din_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        din = 9'd77; din_last = 1'b1; din_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("gap_idle_valid", {31'd0, sel_valid}, 32'd0);
        chk("gap_idle_ready", {31'd0, sel_ready}, 32'd1);
        send("gap_b1", 9'd6, 1'b1);
        check_res("gap", 11, 2, 1'b0, 1'b1);
        handshake("gap");

        // Asynchronous reset while a result is pending
        sel = 0;
        do_reset();
        send("arst_b0", 9'd3, 1'b1);
        chk("arst_pre_valid", {31'd0, sel_valid}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_dout",  {16'd0, m_dout}, 32'd0);
        chk("arst_count", {27'd0, m_count}, 32'd0);
        chk("arst_last",  {31'd0, m_last}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Reset mid-burst discards the partial sum
        send("mid_b0", 9'd50, 1'b0);
        send("mid_b1", 9'd60, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        send("mid_b2", 9'd7, 1'b1);
        check_res("mid", 7, 1, 1'b0, 1'b1);
        handshake("mid");

        // MAX_BEATS=1: every beat closes its burst
        sel = 3;
        do_reset();
        send("one_b0", 9'd200, 1'b0);
        check_res("one_a", 200, 1, 1'b0, 1'b0);
        handshake("one_a");
        send("one_b1", 9'd8, 1'b1);
        check_res("one_b", 8, 1, 1'b0, 1'b1);
        handshake("one_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
